// File: rtl/bit_serial_adder.sv
// Bit-serial adder: streams two WIDTH-bit operands LSB-first through one adder_1bit,
// recirculating the carry, and returns {cout, sum} over a valid/ready handshake.

module adder_1bit #(
   parameter int IMPL_TYPE = 0
) (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   generate
      if (IMPL_TYPE == 0) begin : g_xor_mux
         logic p;
         assign p    = a ^ b;
         assign sum  = p ^ cin;
         assign cout = p ? cin : a;
      end else if (IMPL_TYPE == 1) begin : g_maj_not
         logic maj_c;
         logic maj_n;
         // sum = MAJ(~cout, cin, MAJ(a, b, ~cin))
         assign maj_c = (a & b) | (a & cin) | (b & cin);
         assign maj_n = (a & b) | (a & ~cin) | (b & ~cin);
         assign cout  = maj_c;
         assign sum   = (~maj_c & cin) | (~maj_c & maj_n) | (cin & maj_n);
      end else begin : g_bad_impl
         $error("adder_1bit: unsupported IMPL_TYPE %0d", IMPL_TYPE);
         assign sum  = 1'b0;
         assign cout = 1'b0;
      end
   endgenerate

endmodule

module bit_serial_adder #(
   parameter int unsigned WIDTH     = 8,
   parameter int          IMPL_TYPE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] res_sum_q, res_sum_d;
   logic             res_cout_q, res_cout_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bit_sum;
   logic             bit_cout;
   logic [WIDTH-1:0] sum_shift;

   adder_1bit #(
      .IMPL_TYPE(IMPL_TYPE)
   ) u_adder (
      .a   (a_q[0]),
      .b   (b_q[0]),
      .cin (carry_q),
      .sum (bit_sum),
      .cout(bit_cout)
   );

   // Shift expression avoids an empty slice when WIDTH == 1.
   assign sum_shift = (sum_q >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sum_d      = sum_q;
      carry_d    = carry_q;
      cnt_d      = cnt_q;
      res_sum_d  = res_sum_q;
      res_cout_d = res_cout_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_cin;
               sum_d   = '0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = sum_shift;
            carry_d = bit_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               // Latch the result separately so it survives the next operand load.
               res_sum_d  = sum_shift;
               res_cout_d = bit_cout;
               state_d    = StDone;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         res_sum_q  <= '0;
         res_cout_q <= 1'b0;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sum_q      <= sum_d;
         res_sum_q  <= res_sum_d;
         res_cout_q <= res_cout_d;
         carry_q    <= carry_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign out_sum   = res_sum_q;
   assign out_cout  = res_cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks of bit_serial_adder across widths 1/8/16 and both adder styles.

module tb_bit_serial_adder;

   logic clk;
   logic rst_n;

   // m: WIDTH=8 IMPL 0, e: WIDTH=8 IMPL 1, w1: WIDTH=1 IMPL 1, w16: WIDTH=16 IMPL 0
   logic        m_in_valid, m_in_ready, m_in_cin, m_out_valid, m_out_ready, m_out_cout, m_busy;
   logic [7:0]  m_in_a, m_in_b, m_out_sum;
   logic        e_in_valid, e_in_ready, e_in_cin, e_out_valid, e_out_ready, e_out_cout, e_busy;
   logic [7:0]  e_in_a, e_in_b, e_out_sum;
   logic        w1_in_valid, w1_in_ready, w1_in_cin, w1_out_valid, w1_out_ready, w1_out_cout;
   logic        w1_busy;
   logic [0:0]  w1_in_a, w1_in_b, w1_out_sum;
   logic        w16_in_valid, w16_in_ready, w16_in_cin, w16_out_valid, w16_out_ready;
   logic        w16_out_cout, w16_busy;
   logic [15:0] w16_in_a, w16_in_b, w16_out_sum;

   int n_checks = 0;
   int n_pass   = 0;

   bit_serial_adder #(.WIDTH(8), .IMPL_TYPE(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_a(m_in_a),
      .in_b(m_in_b), .in_cin(m_in_cin), .out_valid(m_out_valid), .out_ready(m_out_ready),
      .out_sum(m_out_sum), .out_cout(m_out_cout), .busy(m_busy)
   );

   bit_serial_adder #(.WIDTH(8), .IMPL_TYPE(1)) u_dut_maj (
      .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready), .in_a(e_in_a),
      .in_b(e_in_b), .in_cin(e_in_cin), .out_valid(e_out_valid), .out_ready(e_out_ready),
      .out_sum(e_out_sum), .out_cout(e_out_cout), .busy(e_busy)
   );

   bit_serial_adder #(.WIDTH(1), .IMPL_TYPE(1)) u_dut_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(w1_in_valid), .in_ready(w1_in_ready), .in_a(w1_in_a),
      .in_b(w1_in_b), .in_cin(w1_in_cin), .out_valid(w1_out_valid), .out_ready(w1_out_ready),
      .out_sum(w1_out_sum), .out_cout(w1_out_cout), .busy(w1_busy)
   );

   bit_serial_adder #(.WIDTH(16), .IMPL_TYPE(0)) u_dut_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(w16_in_valid), .in_ready(w16_in_ready),
      .in_a(w16_in_a), .in_b(w16_in_b), .in_cin(w16_in_cin), .out_valid(w16_out_valid),
      .out_ready(w16_out_ready), .out_sum(w16_out_sum), .out_cout(w16_out_cout), .busy(w16_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one request to the main DUT; returns 1 ns after the accepting edge.
   task automatic m_start(input logic [7:0] a, input logic [7:0] b, input logic c);
      m_in_a = a; m_in_b = b; m_in_cin = c; m_in_valid = 1'b1;
      @(posedge clk); #1;
      m_in_valid = 1'b0;
   endtask

   task automatic m_wait(output int edges);
      edges = 0;
      while (!m_out_valid && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic test_reset;
      #12;
      n_checks++; if (m_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", m_out_valid); else n_pass++;
      n_checks++; if (m_out_sum !== 8'h00) $display("FAIL reset_out_sum got %h want 00", m_out_sum); else n_pass++;
      n_checks++; if (m_out_cout !== 1'b0) $display("FAIL reset_out_cout got %b want 0", m_out_cout); else n_pass++;
      n_checks++; if (m_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", m_busy); else n_pass++;
      n_checks++; if (m_in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", m_in_ready); else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      int edges;
      m_out_ready = 1'b1;
      m_start(8'h5A, 8'h3C, 1'b0);
      n_checks++; if (m_busy !== 1'b1) $display("FAIL basic_busy_run got %b want 1", m_busy); else n_pass++;
      m_wait(edges);
      n_checks++; if (edges !== 8) $display("FAIL basic_latency got %0d want 8", edges); else n_pass++;
      n_checks++; if (m_out_valid !== 1'b1) $display("FAIL basic_out_valid got %b want 1", m_out_valid); else n_pass++;
      n_checks++; if (m_out_sum !== 8'h96) $display("FAIL basic_sum got %h want 96", m_out_sum); else n_pass++;
      n_checks++; if (m_out_cout !== 1'b0) $display("FAIL basic_cout got %b want 0", m_out_cout); else n_pass++;
      n_checks++; if (m_in_ready !== 1'b0) $display("FAIL basic_in_ready_done got %b want 0", m_in_ready); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (m_out_valid !== 1'b0) $display("FAIL basic_idle_valid got %b want 0", m_out_valid); else n_pass++;
      n_checks++; if (m_in_ready !== 1'b1) $display("FAIL basic_idle_ready got %b want 1", m_in_ready); else n_pass++;
      n_checks++; if (m_out_sum !== 8'h96) $display("FAIL basic_sum_hold got %h want 96", m_out_sum); else n_pass++;
   endtask

   task automatic test_carry;
      logic [7:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
      logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h00};
      logic       vc [3] = '{1'b0, 1'b1, 1'b1};
      logic [7:0] xs [3] = '{8'h00, 8'hFF, 8'h01};
      logic       xc [3] = '{1'b1, 1'b1, 1'b0};
      int edges;
      m_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         m_start(va[i], vb[i], vc[i]);
         m_wait(edges);
         n_checks++; if (m_out_valid !== 1'b1) $display("FAIL carry%0d_valid got %b want 1", i, m_out_valid); else n_pass++;
         n_checks++; if (m_out_sum !== xs[i]) $display("FAIL carry%0d_sum got %h want %h", i, m_out_sum, xs[i]); else n_pass++;
         n_checks++; if (m_out_cout !== xc[i]) $display("FAIL carry%0d_cout got %b want %b", i, m_out_cout, xc[i]); else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure;
      int edges;
      m_out_ready = 1'b0;
      m_start(8'h81, 8'h7F, 1'b0);
      m_wait(edges);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++; if (m_out_valid !== 1'b1) $display("FAIL bp%0d_valid got %b want 1", i, m_out_valid); else n_pass++;
         n_checks++; if (m_out_sum !== 8'h00) $display("FAIL bp%0d_sum got %h want 00", i, m_out_sum); else n_pass++;
         n_checks++; if (m_out_cout !== 1'b1) $display("FAIL bp%0d_cout got %b want 1", i, m_out_cout); else n_pass++;
         n_checks++; if (m_in_ready !== 1'b0) $display("FAIL bp%0d_in_ready got %b want 0", i, m_in_ready); else n_pass++;
      end
      m_out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (m_out_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", m_out_valid); else n_pass++;
      n_checks++; if (m_in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", m_in_ready); else n_pass++;
   endtask

   task automatic test_ignore_in_run;
      int edges;
      m_out_ready = 1'b1;
      m_start(8'h11, 8'h22, 1'b0);
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      m_in_a = 8'hFF; m_in_b = 8'hFF; m_in_cin = 1'b1; m_in_valid = 1'b1;
      n_checks++; if (m_in_ready !== 1'b0) $display("FAIL ignore_ready0 got %b want 0", m_in_ready); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (m_in_ready !== 1'b0) $display("FAIL ignore_ready1 got %b want 0", m_in_ready); else n_pass++;
      m_in_valid = 1'b0;
      m_wait(edges);
      n_checks++; if (m_out_sum !== 8'h33) $display("FAIL ignore_sum got %h want 33", m_out_sum); else n_pass++;
      n_checks++; if (m_out_cout !== 1'b0) $display("FAIL ignore_cout got %b want 0", m_out_cout); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run;
      int edges;
      m_out_ready = 1'b1;
      m_start(8'h77, 8'h11, 1'b0);
      for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      n_checks++; if (m_out_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", m_out_valid); else n_pass++;
      n_checks++; if (m_busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", m_busy); else n_pass++;
      n_checks++; if (m_out_sum !== 8'h00) $display("FAIL rst_mid_sum got %h want 00", m_out_sum); else n_pass++;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      m_start(8'h12, 8'h34, 1'b0);
      m_wait(edges);
      n_checks++; if (m_out_valid !== 1'b1) $display("FAIL rst_after_valid got %b want 1", m_out_valid); else n_pass++;
      n_checks++; if (m_out_sum !== 8'h46) $display("FAIL rst_after_sum got %h want 46", m_out_sum); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_width1;
      logic [0:0] ta [2] = '{1'b1, 1'b1};
      logic [0:0] tb [2] = '{1'b1, 1'b0};
      logic       tc [2] = '{1'b1, 1'b0};
      logic [0:0] xs [2] = '{1'b1, 1'b1};
      logic       xc [2] = '{1'b1, 1'b0};
      w1_out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         w1_in_a = ta[i]; w1_in_b = tb[i]; w1_in_cin = tc[i]; w1_in_valid = 1'b1;
         @(posedge clk); #1;
         w1_in_valid = 1'b0;
         n_checks++; if (w1_out_valid !== 1'b0) $display("FAIL w1_%0d_run_valid got %b want 0", i, w1_out_valid); else n_pass++;
         @(posedge clk); #1;
         n_checks++; if (w1_out_valid !== 1'b1) $display("FAIL w1_%0d_valid got %b want 1", i, w1_out_valid); else n_pass++;
         n_checks++; if (w1_out_sum !== xs[i]) $display("FAIL w1_%0d_sum got %b want %b", i, w1_out_sum, xs[i]); else n_pass++;
         n_checks++; if (w1_out_cout !== xc[i]) $display("FAIL w1_%0d_cout got %b want %b", i, w1_out_cout, xc[i]); else n_pass++;
         @(posedge clk); #1;
         n_checks++; if (w1_in_ready !== 1'b1) $display("FAIL w1_%0d_ready got %b want 1", i, w1_in_ready); else n_pass++;
      end
      w1_out_ready = 1'b0;
   endtask

   task automatic test_random_equiv;
      logic [15:0] a, b;
      logic        c;
      logic [8:0]  x8;
      logic [1:0]  x1;
      logic [16:0] x16;
      int          edges;
      m_out_ready = 1'b0; e_out_ready = 1'b0; w1_out_ready = 1'b0; w16_out_ready = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
         x8  = 9'(a[7:0]) + 9'(b[7:0]) + 9'(c);
         x1  = 2'(a[0]) + 2'(b[0]) + 2'(c);
         x16 = 17'(a) + 17'(b) + 17'(c);
         m_in_a = a[7:0]; m_in_b = b[7:0]; m_in_cin = c;
         e_in_a = a[7:0]; e_in_b = b[7:0]; e_in_cin = c;
         w1_in_a = a[0]; w1_in_b = b[0]; w1_in_cin = c;
         w16_in_a = a; w16_in_b = b; w16_in_cin = c;
         m_in_valid = 1'b1; e_in_valid = 1'b1; w1_in_valid = 1'b1; w16_in_valid = 1'b1;
         @(posedge clk); #1;
         m_in_valid = 1'b0; e_in_valid = 1'b0; w1_in_valid = 1'b0; w16_in_valid = 1'b0;
         edges = 0;
         while (!(m_out_valid && e_out_valid && w1_out_valid && w16_out_valid) && edges < 40) begin
            @(posedge clk); #1;
            edges++;
         end
         n_checks++; if ({m_out_cout, m_out_sum} !== x8) $display("FAIL rnd%0d_w8_impl0 got %h want %h (a=%h b=%h c=%b)", i, {m_out_cout, m_out_sum}, x8, a[7:0], b[7:0], c); else n_pass++;
         n_checks++; if ({e_out_cout, e_out_sum} !== x8) $display("FAIL rnd%0d_w8_impl1 got %h want %h (a=%h b=%h c=%b)", i, {e_out_cout, e_out_sum}, x8, a[7:0], b[7:0], c); else n_pass++;
         n_checks++; if ({w1_out_cout, w1_out_sum} !== x1) $display("FAIL rnd%0d_w1_impl1 got %b want %b", i, {w1_out_cout, w1_out_sum}, x1); else n_pass++;
         n_checks++; if ({w16_out_cout, w16_out_sum} !== x16) $display("FAIL rnd%0d_w16_impl0 got %h want %h (a=%h b=%h c=%b)", i, {w16_out_cout, w16_out_sum}, x16, a, b, c); else n_pass++;
         if (edges >= 40) begin
            n_checks++;
            $display("FAIL rnd%0d_timeout got %0d edges want < 40", i, edges);
         end
         m_out_ready = 1'b1; e_out_ready = 1'b1; w1_out_ready = 1'b1; w16_out_ready = 1'b1;
         @(posedge clk); #1;
         m_out_ready = 1'b0; e_out_ready = 1'b0; w1_out_ready = 1'b0; w16_out_ready = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      m_in_valid = 1'b0; m_in_a = '0; m_in_b = '0; m_in_cin = 1'b0; m_out_ready = 1'b0;
      e_in_valid = 1'b0; e_in_a = '0; e_in_b = '0; e_in_cin = 1'b0; e_out_ready = 1'b0;
      w1_in_valid = 1'b0; w1_in_a = '0; w1_in_b = '0; w1_in_cin = 1'b0; w1_out_ready = 1'b0;
      w16_in_valid = 1'b0; w16_in_a = '0; w16_in_b = '0; w16_in_cin = 1'b0; w16_out_ready = 1'b0;
      test_reset();
      test_basic();
      test_carry();
      test_backpressure();
      test_ignore_in_run();
      test_reset_mid_run();
      test_width1();
      test_random_equiv();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
